dmem_mmio_bus: RTL and testbench

- Data-side memory system placed directly downstream of the single-cycle CPU core.
- Consumes the core's data-side outputs: MemWrite, aluout as address, writedata. Produces its readdata input.
- Contains a word-addressed data RAM, LED/switch registers and a down-counting timer with interrupt, all memory-mapped.
- Reads are combinational so the core still completes a lw in one cycle. Writes commit on the rising clock edge.

---
 rtl/dmem_mmio_bus_pkg.sv | 20 ++
 rtl/dmem_mmio_bus_if.sv | 9 +
 rtl/mmio_timer.sv | 65 ++++++
 rtl/dmem_mmio_bus.sv | 73 +++++++
 tb/tb_dmem_mmio_bus.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/dmem_mmio_bus_pkg.sv
// dmem_mmio_bus_pkg: address map and register bit positions shared by the data-side bus
package dmem_mmio_bus_pkg;
    localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
    localparam logic [31:0] RAM_LIMIT    = 32'h0000_0FFF;
    localparam logic [31:0] ADDR_LED     = 32'h0000_7F00;
    localparam logic [31:0] ADDR_SW      = 32'h0000_7F04;
    localparam logic [31:0] ADDR_TCTRL   = 32'h0000_7F10;
    localparam logic [31:0] ADDR_TPRESET = 32'h0000_7F14;
    localparam logic [31:0] ADDR_TCOUNT  = 32'h0000_7F18;
    localparam logic [31:0] ADDR_TSTAT   = 32'h0000_7F1C;
    localparam int TCTRL_EN    = 0;
    localparam int TCTRL_AUTO  = 1;
    localparam int TCTRL_IRQEN = 2;
    localparam int TSTAT_EXP   = 0;

    // Word match on addr[31:2]; byte offset is ignored, no aliasing.
    function automatic logic addr_hit(input logic [31:0] a, input logic [31:0] r);
        return (a & ~32'h3) == r;
    endfunction
endpackage

// File: rtl/dmem_mmio_bus_if.sv
// dmem_mmio_bus_if: core data-side bus (store strobe, address, store data, load data)
interface dmem_mmio_bus_if;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output MemWrite, addr, wdata, input rdata);
    modport slave  (input MemWrite, addr, wdata, output rdata);
endinterface

// File: rtl/mmio_timer.sv
// mmio_timer: down-counting timer with one-shot/auto-reload modes and level interrupt
module mmio_timer
    import dmem_mmio_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tctrl_we_i,
    input  logic        tpreset_we_i,
    input  logic        tstat_we_i,
    input  logic [31:0] wdata_i,
    output logic [2:0]  tctrl_o,
    output logic [31:0] tpreset_o,
    output logic [31:0] tcount_o,
    output logic        exp_o,
    output logic        irq_o
);
    logic [2:0]  tctrl_q, tctrl_d;
    logic [31:0] tpreset_q, tpreset_d, tcount_q, tcount_d;
    logic        exp_q, exp_d, exp_set;

    always_comb begin
        tctrl_d   = tctrl_q;
        tpreset_d = tpreset_q;
        tcount_d  = tcount_q;
        exp_d     = exp_q;
        exp_set   = 1'b0;
        if (tctrl_q[TCTRL_EN]) begin
            if (tcount_q > 32'd1) tcount_d = tcount_q - 32'd1;
            else if (tcount_q == 32'd1) begin
                tcount_d = '0;
                exp_set  = 1'b1;
            end
            else if (tctrl_q[TCTRL_AUTO]) tcount_d = tpreset_q;
            else tctrl_d[TCTRL_EN] = 1'b0;
        end
        if (tpreset_we_i) begin
            tpreset_d = wdata_i;
            tcount_d  = wdata_i;
        end
        if (tctrl_we_i) tctrl_d = wdata_i[2:0];
        // A clear landing on the expiry edge loses to the new expiry.
        if (tstat_we_i && wdata_i[TSTAT_EXP]) exp_d = 1'b0;
        if (exp_set) exp_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tctrl_q   <= '0;
            tpreset_q <= '0;
            tcount_q  <= '0;
            exp_q     <= 1'b0;
        end else begin
            tctrl_q   <= tctrl_d;
            tpreset_q <= tpreset_d;
            tcount_q  <= tcount_d;
            exp_q     <= exp_d;
        end
    end

    assign tctrl_o   = tctrl_q;
    assign tpreset_o = tpreset_q;
    assign tcount_o  = tcount_q;
    assign exp_o     = exp_q;
    assign irq_o     = exp_q & tctrl_q[TCTRL_IRQEN];
endmodule

// File: rtl/dmem_mmio_bus.sv
// dmem_mmio_bus: data RAM plus memory-mapped LED, switches and timer behind the core's data port
module dmem_mmio_bus
    import dmem_mmio_bus_pkg::*;
#(
    parameter int DM_WORDS = 1024,
    parameter int SW_W     = 16
) (
    input  logic            clk,
    input  logic            rst,
    dmem_mmio_bus_if.slave  bus,
    input  logic [SW_W-1:0] sw,
    output logic [SW_W-1:0] led,
    output logic            irq
);
    localparam int AW = $clog2(DM_WORDS);

    logic [31:0]     ram_q [DM_WORDS];
    logic [SW_W-1:0] led_q, led_d, sw_meta_q, sw_sync_q;
    logic [AW-1:0]   ram_idx;
    logic            ram_hit;
    logic [2:0]      tctrl;
    logic [31:0]     tpreset, tcount;
    logic            exp_flag;
    logic            unused_addr;

    assign unused_addr = ^bus.addr[1:0];
    assign ram_idx     = bus.addr[AW+1:2];
    assign ram_hit     = (bus.addr & ~RAM_LIMIT) == RAM_BASE && {22'd0, bus.addr[11:2]} < 32'(DM_WORDS);

    always_ff @(posedge clk) begin
        if (bus.MemWrite && ram_hit) ram_q[ram_idx] <= bus.wdata;
    end

    assign led_d = (bus.MemWrite && addr_hit(bus.addr, ADDR_LED)) ? bus.wdata[SW_W-1:0] : led_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            led_q     <= led_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    mmio_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .tctrl_we_i   (bus.MemWrite && addr_hit(bus.addr, ADDR_TCTRL)),
        .tpreset_we_i (bus.MemWrite && addr_hit(bus.addr, ADDR_TPRESET)),
        .tstat_we_i   (bus.MemWrite && addr_hit(bus.addr, ADDR_TSTAT)),
        .wdata_i      (bus.wdata),
        .tctrl_o      (tctrl),
        .tpreset_o    (tpreset),
        .tcount_o     (tcount),
        .exp_o        (exp_flag),
        .irq_o        (irq)
    );

    always_comb begin
        bus.rdata = ram_hit                          ? ram_q[ram_idx] :
                    addr_hit(bus.addr, ADDR_LED)     ? 32'(led_q) :
                    addr_hit(bus.addr, ADDR_SW)      ? 32'(sw_sync_q) :
                    addr_hit(bus.addr, ADDR_TCTRL)   ? {29'd0, tctrl} :
                    addr_hit(bus.addr, ADDR_TPRESET) ? tpreset :
                    addr_hit(bus.addr, ADDR_TCOUNT)  ? tcount :
                    addr_hit(bus.addr, ADDR_TSTAT)   ? {31'd0, exp_flag} : 32'd0;
    end

    assign led = led_q;
endmodule

// File: tb/tb_dmem_mmio_bus.sv
// tb_dmem_mmio_bus: directed checks of RAM, LED/switch and timer behaviour of dmem_mmio_bus
module tb_dmem_mmio_bus;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] sw  = 16'h0;
    logic [15:0] led;
    logic        irq;
    int          nvec = 0;
    int          nmis = 0;

    dmem_mmio_bus_if bus ();

    dmem_mmio_bus #(.DM_WORDS(1024), .SW_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .sw  (sw),
        .led (led),
        .irq (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite = 1'b1;
        bus.addr     = a;
        bus.wdata    = d;
        tick();
        bus.MemWrite = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(tag, bus.rdata, exp);
    endtask

    initial begin
        bus.MemWrite = 1'b0;
        bus.addr     = 32'h0;
        bus.wdata    = 32'h0;
        #1;
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rd("rst_tctrl", 32'h7F10, 32'h0);
        rd("rst_tcount", 32'h7F18, 32'h0);
        rd("rst_tstat", 32'h7F1C, 32'h0);
        #7 rst = 1'b1;
        tick();

        // RAM, boundaries and unmapped space
        wr(32'h0000_0010, 32'hDEADBEEF);
        rd("ram_10", 32'h0000_0010, 32'hDEADBEEF);
        wr(32'h0000_0014, 32'h0);
        rd("ram_14", 32'h0000_0014, 32'h0);
        wr(32'h0000_0000, 32'h11111111);
        wr(32'h0000_0FFC, 32'hCAFEF00D);
        rd("ram_last", 32'h0000_0FFC, 32'hCAFEF00D);
        wr(32'h0000_5000, 32'h12345678);
        wr(32'h0000_1000, 32'h55555555);
        rd("unmapped_5000", 32'h0000_5000, 32'h0);
        rd("unmapped_1000", 32'h0000_1000, 32'h0);
        rd("ram_0_intact", 32'h0000_0000, 32'h11111111);

        // LED and synchronized switches
        wr(32'h0000_7F00, 32'h0000_00A5);
        chk("led_pin", 32'(led), 32'h0000_00A5);
        rd("led_read", 32'h0000_7F00, 32'h0000_00A5);
        rd("led_alias", 32'h0001_7F00, 32'h0);
        sw = 16'h1234;
        rd("sw_edge0", 32'h0000_7F04, 32'h0);
        tick();
        rd("sw_edge1", 32'h0000_7F04, 32'h0);
        tick();
        rd("sw_edge2", 32'h0000_7F04, 32'h0000_1234);

        // One-shot: preset 5, then enable with IRQEN
        wr(32'h0000_7F14, 32'd5);
        rd("os_tpreset", 32'h0000_7F14, 32'd5);
        rd("os_load", 32'h0000_7F18, 32'd5);
        wr(32'h0000_7F10, 32'h5);
        rd("os_tctrl", 32'h0000_7F10, 32'h5);
        rd("os_cnt5", 32'h0000_7F18, 32'd5);
        for (int i = 4; i >= 1; i--) begin
            tick();
            rd($sformatf("os_cnt%0d", i), 32'h0000_7F18, 32'(i));
            chk($sformatf("os_irq_low%0d", i), 32'(irq), 32'h0);
        end
        tick();
        rd("os_cnt0", 32'h0000_7F18, 32'd0);
        rd("os_exp", 32'h0000_7F1C, 32'h1);
        chk("os_irq", 32'(irq), 32'h1);
        rd("os_en_still", 32'h0000_7F10, 32'h5);
        tick();
        rd("os_en_clr", 32'h0000_7F10, 32'h4);
        rd("os_hold0", 32'h0000_7F18, 32'd0);
        tick();
        rd("os_hold0b", 32'h0000_7F18, 32'd0);

        // Auto-reload with W1C on and off the expiry edge
        wr(32'h0000_7F1C, 32'h1);
        rd("ar_exp_clr", 32'h0000_7F1C, 32'h0);
        chk("ar_irq_clr", 32'(irq), 32'h0);
        wr(32'h0000_7F14, 32'd3);
        wr(32'h0000_7F10, 32'h3);
        rd("ar_cnt3", 32'h0000_7F18, 32'd3);
        tick();
        rd("ar_cnt2", 32'h0000_7F18, 32'd2);
        tick();
        rd("ar_cnt1", 32'h0000_7F18, 32'd1);
        wr(32'h0000_7F1C, 32'h1);
        rd("ar_cnt0", 32'h0000_7F18, 32'd0);
        rd("ar_set_wins", 32'h0000_7F1C, 32'h1);
        tick();
        rd("ar_reload3", 32'h0000_7F18, 32'd3);
        rd("ar_exp_held", 32'h0000_7F1C, 32'h1);
        wr(32'h0000_7F1C, 32'h1);
        rd("ar_cnt2b", 32'h0000_7F18, 32'd2);
        rd("ar_w1c", 32'h0000_7F1C, 32'h0);
        tick();
        rd("ar_cnt1b", 32'h0000_7F18, 32'd1);
        tick();
        rd("ar_cnt0b", 32'h0000_7F18, 32'd0);
        rd("ar_exp2", 32'h0000_7F1C, 32'h1);
        tick();
        rd("ar_reload3b", 32'h0000_7F18, 32'd3);
        wr(32'h0000_7F10, 32'h7);
        rd("ar_cnt_after_ctrl", 32'h0000_7F18, 32'd2);
        chk("ar_irq_on", 32'(irq), 32'h1);

        // Asynchronous reset mid-count, between edges
        #1 rst = 1'b0;
        #1;
        chk("ar_rst_led", 32'(led), 32'h0);
        chk("ar_rst_irq", 32'(irq), 32'h0);
        rd("ar_rst_tcount", 32'h0000_7F18, 32'h0);
        rd("ar_rst_tctrl", 32'h0000_7F10, 32'h0);
        rd("ar_rst_tstat", 32'h0000_7F1C, 32'h0);
        #1 rst = 1'b1;
        tick();
        tick();
        rd("post_rst_tcount", 32'h0000_7F18, 32'h0);
        rd("post_rst_tctrl", 32'h0000_7F10, 32'h0);
        rd("post_rst_ram10", 32'h0000_0010, 32'hDEADBEEF);
        rd("post_rst_sw", 32'h0000_7F04, 32'h0000_1234);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
